// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: radix-2 restoring division on magnitudes, then sign correction.
// Optional macro SDIV_OVF_FLAG_EN adds an ovf output flagging the -2^(WIDTH-1) / -1 case.
module seq_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef SDIV_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] dvd_shift;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] q_mag;
  logic [CW-1:0]    cnt;
`ifdef SDIV_OVF_FLAG_EN
  logic             ovf_case;
`endif

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Magnitudes stay unsigned in WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // One restoring step: partial remainder never exceeds |divisor|, so WIDTH+1 bits suffice.
  assign shifted = {rem_reg, dvd_shift[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dsr_mag});
  assign diff    = WIDTH'(shifted - {1'b0, dsr_mag});
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dvd_shift   <= '0;
      dsr_mag     <= '0;
      rem_reg     <= '0;
      q_mag       <= '0;
      cnt         <= '0;
`ifdef SDIV_OVF_FLAG_EN
      ovf         <= 1'b0;
      ovf_case    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
`ifdef SDIV_OVF_FLAG_EN
              ovf         <= 1'b0;
`endif
              state       <= DONE;
            end else begin
              sign_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r    <= dividend[WIDTH-1];
              dvd_shift <= abs_val(dividend);
              dsr_mag   <= abs_val(divisor);
              rem_reg   <= '0;
              q_mag     <= '0;
              cnt       <= CW'(WIDTH - 1);
`ifdef SDIV_OVF_FLAG_EN
              ovf_case  <= (dividend == MIN_VAL) && (divisor == '1);
`endif
              state     <= ITER;
            end
          end
        end
        ITER: begin
          rem_reg   <= ge ? diff : shifted[WIDTH-1:0];
          q_mag     <= {q_mag[WIDTH-2:0], ge};
          dvd_shift <= dvd_shift << 1;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          quotient    <= sign_q ? -q_mag : q_mag;
          remainder   <= sign_r ? -rem_reg : rem_reg;
          div_by_zero <= 1'b0;
`ifdef SDIV_OVF_FLAG_EN
          ovf         <= ovf_case;
`endif
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: scoreboard of expected results, checked on each done.
module tb_seq_signed_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
`ifdef SDIV_OVF_FLAG_EN
  logic         ovf;
`endif

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
`ifdef SDIV_OVF_FLAG_EN
    .ovf        (ovf),
`endif
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference model built from the language's own truncating / and %.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sbv;
    sa  = $signed(a);
    sbv = $signed(b);
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 0;
    end else begin
      e.q   = W'(sa / sbv);
      e.r   = W'(sa % sbv);
      e.dbz = 1'b0;
      e.ovf = (sa == -(2 ** (W - 1))) && (sbv == -1);
      e.lat = W + 1;
    end
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch_at);
    exp_t e;
    int edges, bcnt;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push_exp(a, b);
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    bcnt  = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy) bcnt++;
      if (edges == glitch_at) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    if (busy) bcnt++;
    e = sb.pop_front();
    $display("op %0d / %0d -> q=%h r=%h dbz=%b after %0d edges",
             $signed(a), $signed(b), quotient, remainder, div_by_zero, edges);
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", edges, e.lat);
    check("busy_cycles", bcnt, e.lat + 1);
    check("quotient", {24'd0, quotient}, {24'd0, e.q});
    check("remainder", {24'd0, remainder}, {24'd0, e.r});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
`ifdef SDIV_OVF_FLAG_EN
    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("hold_q", {24'd0, quotient}, {24'd0, e.q});
  endtask

  initial begin
    int seen;
    #12 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {24'd0, quotient}, 32'd0);
    check("rst_r", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

    run_op(8'd100, 8'd7, -1);
    run_op(8'h9C, 8'd7, -1);
    run_op(8'd100, 8'hF9, -1);
    run_op(8'h9C, 8'hF9, -1);
    run_op(8'h55, 8'h00, -1);
    run_op(8'd9, 8'd3, -1);
    run_op(8'h80, 8'hFF, -1);
    run_op(8'h7F, 8'h01, -1);
    run_op(8'h80, 8'h7F, -1);
    run_op(8'd100, 8'd7, 3);
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)), -1);
    end

    // Abandon an operation with reset mid-iteration.
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    $display("reset mid-operation: q=%h r=%h busy=%b done=%b", quotient, remainder, busy, done);
    check("midrst_q", {24'd0, quotient}, 32'd0);
    check("midrst_r", {24'd0, remainder}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    #2 rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no_done_after_rst", seen, 0);
    run_op(8'd100, 8'd7, -1);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
